// File: rtl/mcpu_pkg.sv
// Shared definitions for the multi-cycle MIPS datapath: fetch FSM encoding,
// reset PC and the canonical nop word.
package mcpu_pkg;

  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_e;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  function automatic logic word_aligned(input logic [31:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/ifetch_unit_if.sv
// Instruction-memory port: valid/ready request channel plus a response
// channel with no backpressure.
interface ifetch_unit_if;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data
  );
endinterface

// File: rtl/ifetch_unit_pc_reg.sv
// Architectural PC register with load enable; comes out of reset at RESET_PC.
module pc_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] d,
  output logic [31:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RESET_PC;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Fetch stage: owns PC, issues one instruction-memory request per
// fetch_start and latches the returned word into the instruction register.
module ifetch_unit
  import mcpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                pc_write,
  input  logic [31:0]         npc,
  input  logic                fetch_start,
  ifetch_unit_if.master       imem,
  output logic [31:0]         pc,
  output logic [31:0]         ir,
  output logic                ir_valid,
  output logic                fetch_done,
  output logic                busy,
  output logic                misalign_fault,
  output logic                proto_err,
  output logic [31:0]         fetch_count
);

  if_state_e   state_reg;
  logic [31:0] req_addr_reg;
  logic        req_valid_reg;
  logic [31:0] ir_reg;
  logic        ir_valid_reg;
  logic        fetch_done_reg;
  logic        busy_reg;
  logic        misalign_reg;
  logic        proto_err_reg;
  logic [31:0] fetch_count_reg;

  logic        idle;
  logic        pc_load;
  logic [31:0] pc_q;
  logic [31:0] eff_addr;

  assign idle     = (state_reg == IF_IDLE);
  assign pc_load  = pc_write && idle;
  // A same-cycle pc_write redirects the fetch to the new PC.
  assign eff_addr = pc_write ? npc : pc_q;

  pc_reg #(.RESET_PC(RESET_PC)) u_pc_reg (
    .clk  (clk),
    .rst  (rst),
    .load (pc_load),
    .d    (npc),
    .q    (pc_q)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= IF_IDLE;
      req_addr_reg    <= RESET_PC;
      req_valid_reg   <= 1'b0;
      ir_reg          <= NOP_INSTR;
      ir_valid_reg    <= 1'b0;
      fetch_done_reg  <= 1'b0;
      busy_reg        <= 1'b0;
      misalign_reg    <= 1'b0;
      proto_err_reg   <= 1'b0;
      fetch_count_reg <= '0;
    end else begin
      fetch_done_reg <= 1'b0;
      unique case (state_reg)
        IF_IDLE: begin
          if (pc_write) begin
            ir_valid_reg <= 1'b0;
          end
          if (imem.imem_rsp_valid) begin
            proto_err_reg <= 1'b1;
          end
          if (fetch_start) begin
            if (word_aligned(eff_addr)) begin
              state_reg     <= IF_REQ;
              req_addr_reg  <= eff_addr;
              req_valid_reg <= 1'b1;
              busy_reg      <= 1'b1;
            end else begin
              misalign_reg <= 1'b1;
            end
          end
        end
        IF_REQ: begin
          if (pc_write || fetch_start || imem.imem_rsp_valid) begin
            proto_err_reg <= 1'b1;
          end
          if (imem.imem_req_ready) begin
            state_reg     <= IF_WAIT;
            req_valid_reg <= 1'b0;
          end
        end
        IF_WAIT: begin
          if (pc_write || fetch_start) begin
            proto_err_reg <= 1'b1;
          end
          if (imem.imem_rsp_valid) begin
            state_reg       <= IF_IDLE;
            busy_reg        <= 1'b0;
            ir_reg          <= imem.imem_rsp_data;
            ir_valid_reg    <= 1'b1;
            fetch_done_reg  <= 1'b1;
            fetch_count_reg <= fetch_count_reg + 32'd1;
          end
        end
        default: begin
          state_reg     <= IF_IDLE;
          req_valid_reg <= 1'b0;
          busy_reg      <= 1'b0;
        end
      endcase
    end
  end

  assign imem.imem_req_valid = req_valid_reg;
  assign imem.imem_req_addr  = req_addr_reg;
  assign pc                  = pc_q;
  assign ir                  = ir_reg;
  assign ir_valid            = ir_valid_reg;
  assign fetch_done          = fetch_done_reg;
  assign busy                = busy_reg;
  assign misalign_fault      = misalign_reg;
  assign proto_err           = proto_err_reg;
  assign fetch_count         = fetch_count_reg;

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage of the multi-cycle MIPS datapath. It owns the architectural PC register: it latches the next-PC value produced by the next-PC logic and fetches the instruction word at that PC through a valid/ready instruction-memory port. It holds the result in the instruction register for the decode stage. The control FSM sequences it with one-cycle `pc_write` and `fetch_start` pulses.

## Interface
- `RESET_PC`, default 32'h0000_3000: PC value after reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-high reset.
- `pc_write`  in  1: load `npc` into PC; pulse from control at end of EX.
- `npc`  in  32: next PC from next-PC logic.
- `fetch_start`  in  1: begin fetch at the current PC (or at `npc`, see Operation).
- `imem_req_valid`  out  1: request valid.
- `imem_req_addr`  out  32: byte address of the requested word.
- `imem_req_ready`  in  1: memory accepts the request.
- `imem_rsp_valid`  in  1: response data valid.
- `imem_rsp_data`  in  32: instruction word.
- `pc`  out  32: current PC, consumed by the next-PC logic for PC+4 and jump targets.
- `ir`  out  32: instruction register.
- `ir_valid`  out  1: `ir` holds the instruction at `pc`.
- `fetch_done`  out  1: one-cycle pulse when a new `ir` is visible.
- `busy`  out  1: state is not IDLE.
- `misalign_fault`  out  1: sticky; set when a fetch is started with PC[1:0] ≠ 0.
- `proto_err`  out  1: sticky; set on a dropped `pc_write`/`fetch_start` or an unexpected response.
- `fetch_count`  out  32: number of completed fetches; wraps modulo 2^32.

## Operation
- FSM states: IDLE, REQ, WAIT.
- **IDLE**
  - `pc_write`: PC ← `npc`; `ir_valid` ← 0.
  - `fetch_start` with effective address aligned: go to REQ; the request address register ← effective address.
  - Effective address: `npc` if `pc_write` is high in the same cycle, else PC. `pc_write` + `fetch_start` in one cycle therefore fetches the new PC.
  - `fetch_start` with effective address misaligned: stay in IDLE, set `misalign_fault`, issue no request.
- **REQ**
  - `imem_req_valid` = 1 and `imem_req_addr` = the request address register; both stable until accepted.
  - On `imem_req_ready`, go to WAIT.
- **WAIT**
  - On `imem_rsp_valid`: `ir` ← `imem_rsp_data`, `ir_valid` ← 1, `fetch_count` += 1, `fetch_done` pulses the next cycle, return to IDLE.
- Responses are accepted only in WAIT. `imem_rsp_valid` in IDLE or REQ is ignored and sets `proto_err`.
- `pc_write` or `fetch_start` in REQ or WAIT is dropped: PC is unchanged, no new fetch starts, and `proto_err` is set.
- `ir` and `pc` hold their values in every state except on the updates above.
- `busy` = (state ≠ IDLE).

## Timing
- Reset values:
  - state IDLE, `pc` = RESET_PC, `ir` = 0 (sll nop).
  - `ir_valid`, `fetch_done`, `imem_req_valid`, `busy`, `misalign_fault`, `proto_err` = 0.
  - `fetch_count` = 0, `imem_req_addr` = RESET_PC.
- `rst` asserted mid-fetch returns to IDLE immediately. A response arriving after `rst` deasserts is ignored and sets `proto_err`.
- `pc` updates on the edge where `pc_write` is sampled and is visible the next cycle.
- Timeline for `fetch_start` at edge t:
  - `imem_req_valid` high during cycle t+1.
  - With ready at t+1 and response at t+2, `ir` and `fetch_done` are visible in cycle t+3.
  - Minimum latency from `fetch_start` to `fetch_done` is 3 cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Structure
- Shared package `mcpu_pkg`: FSM state encoding (`IF_IDLE`/`IF_REQ`/`IF_WAIT`, 2 bits), `RESET_PC_DEFAULT`, `NOP_INSTR` = 32'h0.
- Optional sub-module `pc_reg`: the PC register with async reset and load enable. The FSM, instruction register and counters stay in `ifetch_unit`.

## Test plan
- Reset:
  - Assert `rst` → `pc` = 32'h0000_3000, `ir` = 0, all flags 0.
  - `fetch_start`, ready = 1, response 32'h2408_0005 two cycles later → `imem_req_addr` = 32'h0000_3000, `ir` = 32'h2408_0005, `fetch_done` pulse, `fetch_count` = 1.
- Same-cycle load and fetch: `pc_write` with `npc` = 32'h0000_3010 together with `fetch_start` → request address 32'h0000_3010, `pc` = 32'h0000_3010.
- Backpressure:
  - Hold `imem_req_ready` = 0 for 5 cycles → `imem_req_valid` and address stable.
  - A `pc_write` during the stall → dropped and `proto_err` = 1.
- Misalignment: `pc_write` with `npc` = 32'h0000_3002, then `fetch_start` → no request, `misalign_fault` = 1, state remains IDLE.
- Stray response and reset:
  - `imem_rsp_valid` while in IDLE → `ir` unchanged, `proto_err` = 1.
  - Assert `rst` while in WAIT → IDLE, `ir_valid` = 0.
- Counter wrap: preload via 2^32−1 back-to-back fetches (or force) → `fetch_count` wraps to 0.
